alu: RTL and testbench

//  Integer execute-stage ALU for the RV32I core.
//  - Decodes the full 32-bit instruction word against the shared opcode masks.
//  - Computes the register/immediate arithmetic, logic, shift, compare, LUI and AUIPC result.
//  - Registers the result on a one-cycle enable strobe.
//  - Operands arrive pre-resolved from the decode/register-read stage; I-type immediates arrive on op2.

---
 rtl/alu_pkg.sv | 59 +++++
 rtl/alu_shifter.sv | 50 +++++
 rtl/alu.sv | 92 +++++++++
 tb/tb_alu.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared types, instruction match masks and the internal ALU operation code
// for the RV32I execute-stage ALU.
//   instruction_t / register_t / opcode_mask_t : 32-bit words
//   M_*        : casez match patterns ('?' = don't care) for each instruction
//   alu_op_e   : decoded datapath operation
//   encode_rtype() : builds an R-type instruction word from its fields
// ----------------------------------------------------------------------------
package alu_pkg;

    typedef logic [31:0] instruction_t;
    typedef logic [31:0] register_t;
    typedef logic [31:0] opcode_mask_t;

    // Layout: funct7 | rs2 | rs1 | funct3 | rd | opcode
    localparam opcode_mask_t M_ADD   = 32'b0000000_??????????_000_?????_0110011;
    localparam opcode_mask_t M_SUB   = 32'b0100000_??????????_000_?????_0110011;
    localparam opcode_mask_t M_SLL   = 32'b0000000_??????????_001_?????_0110011;
    localparam opcode_mask_t M_SLT   = 32'b0000000_??????????_010_?????_0110011;
    localparam opcode_mask_t M_SLTU  = 32'b0000000_??????????_011_?????_0110011;
    localparam opcode_mask_t M_XOR   = 32'b0000000_??????????_100_?????_0110011;
    localparam opcode_mask_t M_SRL   = 32'b0000000_??????????_101_?????_0110011;
    localparam opcode_mask_t M_SRA   = 32'b0100000_??????????_101_?????_0110011;
    localparam opcode_mask_t M_OR    = 32'b0000000_??????????_110_?????_0110011;
    localparam opcode_mask_t M_AND   = 32'b0000000_??????????_111_?????_0110011;

    // Layout: imm[11:0] | rs1 | funct3 | rd | opcode
    localparam opcode_mask_t M_ADDI  = 32'b????????????_?????_000_?????_0010011;
    localparam opcode_mask_t M_SLTI  = 32'b????????????_?????_010_?????_0010011;
    localparam opcode_mask_t M_SLTIU = 32'b????????????_?????_011_?????_0010011;
    localparam opcode_mask_t M_XORI  = 32'b????????????_?????_100_?????_0010011;
    localparam opcode_mask_t M_ORI   = 32'b????????????_?????_110_?????_0010011;
    localparam opcode_mask_t M_ANDI  = 32'b????????????_?????_111_?????_0010011;
    // Immediate shifts keep funct7 in imm[11:5] and shamt in imm[4:0]
    localparam opcode_mask_t M_SLLI  = 32'b0000000_?????_?????_001_?????_0010011;
    localparam opcode_mask_t M_SRLI  = 32'b0000000_?????_?????_101_?????_0010011;
    localparam opcode_mask_t M_SRAI  = 32'b0100000_?????_?????_101_?????_0010011;

    // Layout: imm[31:12] | rd | opcode
    localparam opcode_mask_t M_LUI   = 32'b????????????????????_?????_0110111;
    localparam opcode_mask_t M_AUIPC = 32'b????????????????????_?????_0010111;

    typedef enum logic [3:0] {
        ADD, SUB, SLT, SLTU, AND, OR, XOR, SLL, SRL, SRA, PASS1, ADDPC, NONE
    } alu_op_e;

    function automatic instruction_t encode_rtype(
        input logic [6:0] funct7,
        input logic [4:0] rs2,
        input logic [4:0] rs1,
        input logic [2:0] funct3,
        input logic [4:0] rd,
        input logic [6:0] opcode
    );
        return {funct7, rs2, rs1, funct3, rd, opcode};
    endfunction

endpackage

// File: rtl/alu_shifter.sv
// ----------------------------------------------------------------------------
// alu_shifter
// Purely combinational 32-bit barrel shifter.
//   op1    in  32  value to shift
//   shamt  in  5   shift amount
//   dir    in  1   0 = shift left, 1 = shift right
//   arith  in  1   right shifts fill with op1[31] when set, zeros otherwise
//   result out 32  shifted value
// Left shifts reuse the right-shift stages by bit-reversing the input and
// output, so only one set of log-stages is built.
// ----------------------------------------------------------------------------
module alu_shifter
    import alu_pkg::*;
(
    input  register_t  op1,
    input  logic [4:0] shamt,
    input  logic       dir,
    input  logic       arith,
    output register_t  result
);

    register_t         rev_in;
    register_t         rev_out;
    logic [5:0][31:0]  stage;
    logic              fill;

    // Sign fill only makes sense for right shifts; left shifts always fill 0.
    assign fill = arith & dir & op1[31];

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_rev
            assign rev_in[gi]  = op1[31 - gi];
            assign rev_out[gi] = stage[5][31 - gi];
        end
    endgenerate

    assign stage[0] = dir ? op1 : rev_in;

    generate
        for (gi = 0; gi < 5; gi++) begin : g_stage
            localparam int SH = 1 << gi;
            assign stage[gi + 1] = shamt[gi] ? {{SH{fill}}, stage[gi][31:SH]}
                                             : stage[gi];
        end
    endgenerate

    assign result = dir ? stage[5] : rev_out;

endmodule

// File: rtl/alu.sv
// ----------------------------------------------------------------------------
// alu
// RV32I integer execute-stage ALU with a single registered result.
//   clk     in   1   system clock
//   rst     in   1   synchronous active-high reset (clears result)
//   instr   in   32  instruction being executed (decoded by wildcard match)
//   op1     in   32  rs1 value, or U-immediate for LUI/AUIPC
//   op2     in   32  rs2 value, or sign-extended I-immediate
//   pc      in   32  instruction PC, used by AUIPC
//   enable  in   1   execute strobe; result captured when high at clk edge
//   result  out  32  registered ALU result, held while enable is low
// ----------------------------------------------------------------------------
module alu
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  instruction_t instr,
    input  register_t    op1,
    input  register_t    op2,
    input  register_t    pc,
    input  logic         enable,
    output register_t    result
);

    alu_op_e   op_d;
    register_t shift_res;
    register_t alu_value;
    register_t result_d;
    register_t result_q;

    // Decode: first matching mask wins; unknown encodings produce NONE (0).
    always_comb begin
        op_d = NONE;
        casez (instr)
            M_ADD, M_ADDI:   op_d = ADD;
            M_SUB:           op_d = SUB;
            M_SLL, M_SLLI:   op_d = SLL;
            M_SLT, M_SLTI:   op_d = SLT;
            M_SLTU, M_SLTIU: op_d = SLTU;
            M_XOR, M_XORI:   op_d = XOR;
            M_SRL, M_SRLI:   op_d = SRL;
            M_SRA, M_SRAI:   op_d = SRA;
            M_OR, M_ORI:     op_d = OR;
            M_AND, M_ANDI:   op_d = AND;
            M_LUI:           op_d = PASS1;
            M_AUIPC:         op_d = ADDPC;
            default:         op_d = NONE;
        endcase
    end

    // Only op2[4:0] reaches the shifter, so larger immediates wrap mod 32.
    alu_shifter u_shifter (
        .op1    (op1),
        .shamt  (op2[4:0]),
        .dir    ((op_d == SRL) || (op_d == SRA)),
        .arith  (op_d == SRA),
        .result (shift_res)
    );

    always_comb begin
        alu_value = '0;
        case (op_d)
            ADD:     alu_value = op1 + op2;
            SUB:     alu_value = op1 - op2;
            SLT:     alu_value = {31'b0, $signed(op1) < $signed(op2)};
            SLTU:    alu_value = {31'b0, op1 < op2};
            AND:     alu_value = op1 & op2;
            OR:      alu_value = op1 | op2;
            XOR:     alu_value = op1 ^ op2;
            SLL,
            SRL,
            SRA:     alu_value = shift_res;
            PASS1:   alu_value = op1;
            ADDPC:   alu_value = op1 + pc;
            default: alu_value = '0;
        endcase
    end

    assign result_d = enable ? alu_value : result_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
        end else begin
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_alu.sv
// ----------------------------------------------------------------------------
// tb_alu
// Directed and randomized checks of the alu block against a behavioural
// model written directly from the instruction semantics.
// ----------------------------------------------------------------------------
module tb_alu;

    typedef enum int {
        K_ADD, K_SUB, K_SLT, K_SLTU, K_AND, K_OR, K_XOR, K_SLL, K_SRL, K_SRA,
        K_ADDI, K_SLTI, K_SLTIU, K_ANDI, K_ORI, K_XORI, K_SLLI, K_SRLI, K_SRAI,
        K_LUI, K_AUIPC, K_BAD
    } kind_e;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] pc;
    logic        enable;
    logic [31:0] result;

    int compared   = 0;
    int mismatched = 0;
    int txn        = 0;

    alu dut (
        .clk    (clk),
        .rst    (rst),
        .instr  (instr),
        .op1    (op1),
        .op2    (op2),
        .pc     (pc),
        .enable (enable),
        .result (result)
    );

    always #5 clk = ~clk;

    // Build an instruction word for the given kind with random register/imm fields.
    function automatic logic [31:0] enc(input kind_e k);
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm12;
        logic [19:0] imm20;
        logic [31:0] w;
        rd    = 5'($urandom);
        rs1   = 5'($urandom);
        rs2   = 5'($urandom);
        imm12 = 12'($urandom);
        imm20 = 20'($urandom);
        w     = '0;
        case (k)
            K_ADD:   w = {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
            K_SUB:   w = {7'b0100000, rs2, rs1, 3'b000, rd, 7'b0110011};
            K_SLL:   w = {7'b0000000, rs2, rs1, 3'b001, rd, 7'b0110011};
            K_SLT:   w = {7'b0000000, rs2, rs1, 3'b010, rd, 7'b0110011};
            K_SLTU:  w = {7'b0000000, rs2, rs1, 3'b011, rd, 7'b0110011};
            K_XOR:   w = {7'b0000000, rs2, rs1, 3'b100, rd, 7'b0110011};
            K_SRL:   w = {7'b0000000, rs2, rs1, 3'b101, rd, 7'b0110011};
            K_SRA:   w = {7'b0100000, rs2, rs1, 3'b101, rd, 7'b0110011};
            K_OR:    w = {7'b0000000, rs2, rs1, 3'b110, rd, 7'b0110011};
            K_AND:   w = {7'b0000000, rs2, rs1, 3'b111, rd, 7'b0110011};
            K_ADDI:  w = {imm12, rs1, 3'b000, rd, 7'b0010011};
            K_SLTI:  w = {imm12, rs1, 3'b010, rd, 7'b0010011};
            K_SLTIU: w = {imm12, rs1, 3'b011, rd, 7'b0010011};
            K_XORI:  w = {imm12, rs1, 3'b100, rd, 7'b0010011};
            K_ORI:   w = {imm12, rs1, 3'b110, rd, 7'b0010011};
            K_ANDI:  w = {imm12, rs1, 3'b111, rd, 7'b0010011};
            K_SLLI:  w = {7'b0000000, rs2, rs1, 3'b001, rd, 7'b0010011};
            K_SRLI:  w = {7'b0000000, rs2, rs1, 3'b101, rd, 7'b0010011};
            K_SRAI:  w = {7'b0100000, rs2, rs1, 3'b101, rd, 7'b0010011};
            K_LUI:   w = {imm20, rd, 7'b0110111};
            K_AUIPC: w = {imm20, rd, 7'b0010111};
            default: begin
                case ($urandom_range(0, 3))
                    0:       w = {7'b0000001, rs2, rs1, 3'b000, rd, 7'b0110011}; // MUL
                    1:       w = {imm12, rs1, 3'b010, rd, 7'b0000011};           // LW
                    2:       w = {7'b0100000, rs2, rs1, 3'b001, rd, 7'b0010011}; // bad SLLI
                    default: w = 32'h0000_0000;
                endcase
            end
        endcase
        return w;
    endfunction

    // Reference semantics of each instruction kind.
    function automatic logic [31:0] model(input kind_e k, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] p);
        int unsigned sh;
        sh = b % 32;
        case (k)
            K_ADD, K_ADDI:   return a + b;
            K_SUB:           return a - b;
            K_SLT, K_SLTI:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            K_SLTU, K_SLTIU: return (a < b) ? 32'd1 : 32'd0;
            K_AND, K_ANDI:   return a & b;
            K_OR, K_ORI:     return a | b;
            K_XOR, K_XORI:   return a ^ b;
            K_SLL, K_SLLI:   return a << sh;
            K_SRL, K_SRLI:   return a >> sh;
            K_SRA, K_SRAI:   return 32'($signed(a) >>> sh);
            K_LUI:           return a;
            K_AUIPC:         return a + p;
            default:         return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] expv);
        compared++;
        assert (result === expv) else begin
            mismatched++;
            $error("FAIL %s: result=%h expected=%h", tag, result, expv);
        end
    endtask

    // One enabled transaction; leaves enable high so consecutive calls are back-to-back.
    task automatic do_op(input kind_e k, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [31:0] expv);
        instr  = enc(k);
        op1    = a;
        op2    = b;
        pc     = p;
        enable = 1'b1;
        @(posedge clk);
        #1;
        txn++;
        $display("txn %0d %s op1=%h op2=%h pc=%h result=%h exp=%h",
                 txn, k.name(), a, b, p, result, expv);
        check(k.name(), expv);
    endtask

    // Idle cycles with scrambled inputs; result must hold.
    task automatic idle(input int n, input logic [31:0] expv);
        for (int i = 0; i < n; i++) begin
            enable = 1'b0;
            instr  = $urandom;
            op1    = $urandom;
            op2    = $urandom;
            pc     = $urandom;
            @(posedge clk);
            #1;
            txn++;
            $display("txn %0d IDLE result=%h exp=%h", txn, result, expv);
            check("hold", expv);
        end
    endtask

    logic [31:0] vals [18] = '{
        32'hFFFFFFFD, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4,
        32'd100, 32'd128, 32'd16000,
        32'hAAAA5555, 32'h5555AAAA, 32'hF0F0F0F0, 32'h0F0F0F0F,
        32'h80000000, 32'h7FFFFFFF, 32'hFFFF0000
    };
    kind_e sweep_ops [6] = '{K_ADD, K_AND, K_OR, K_XOR, K_SRL, K_SLL};

    initial begin
        kind_e       k;
        logic [31:0] a, b, p;

        // Reset with enable also high: reset must win.
        rst    = 1'b1;
        enable = 1'b1;
        instr  = enc(K_ADD);
        op1    = 32'd7;
        op2    = 32'd9;
        pc     = '0;
        repeat (2) @(posedge clk);
        #1;
        $display("txn %0d RESET result=%h exp=00000000", txn, result);
        check("reset", 32'h0);
        rst    = 1'b0;
        enable = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases
        do_op(K_ADD,   32'hFFFFFFFF, 32'h00000001, 32'h0, 32'h00000000);
        idle(2, 32'h00000000);
        do_op(K_XOR,   32'hAAAA5555, 32'h5555AAAA, 32'h0, 32'hFFFFFFFF);
        do_op(K_AND,   32'hF0F0F0F0, 32'h0F0F0F0F, 32'h0, 32'h00000000);
        do_op(K_OR,    32'hFFFF0000, 32'h0000FFFF, 32'h0, 32'hFFFFFFFF);
        do_op(K_SLL,   32'h12345678, 32'd100,      32'h0, 32'h23456780);
        do_op(K_SRL,   32'h90ABCDEF, 32'd4,        32'h0, 32'h090ABCDE);
        do_op(K_SRA,   32'hF0F0F0F0, 32'd4,        32'h0, 32'hFF0F0F0F);
        do_op(K_SLT,   32'hFFFFFFFD, 32'd1,        32'h0, 32'h00000001);
        do_op(K_SLTU,  32'hFFFFFFFD, 32'd1,        32'h0, 32'h00000000);
        do_op(K_SUB,   32'h00000000, 32'd1,        32'h0, 32'hFFFFFFFF);
        do_op(K_SRAI,  32'h80000000, 32'd31,       32'h0, 32'hFFFFFFFF);
        do_op(K_SRLI,  32'h80000000, 32'd31,       32'h0, 32'h00000001);
        do_op(K_SLLI,  32'hDEADBEEF, 32'd0,        32'h0, 32'hDEADBEEF);
        do_op(K_SLTI,  32'h00000005, 32'hFFFFFFFF, 32'h0, 32'h00000000);
        do_op(K_SLTIU, 32'h00000005, 32'hFFFFFFFF, 32'h0, 32'h00000001);
        do_op(K_LUI,   32'hABCDE000, 32'h12345678, 32'h0, 32'hABCDE000);
        do_op(K_BAD,   32'h11111111, 32'h22222222, 32'h0, 32'h00000000);
        do_op(K_AUIPC, 32'h00001000, 32'h5,        32'h00000100, 32'h00001100);

        // Hold, then reset alone, then reset together with enable
        idle(3, 32'h00001100);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        txn++;
        $display("txn %0d RST result=%h exp=00000000", txn, result);
        check("rst_clear", 32'h0);
        do_op(K_ORI, 32'h0000F000, 32'h00000ABC, 32'h0, 32'h0000FABC);
        rst   = 1'b1;
        instr = enc(K_ADD);
        op1   = 32'd5;
        op2   = 32'd6;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        enable = 1'b0;
        txn++;
        $display("txn %0d RST+EN result=%h exp=00000000", txn, result);
        check("rst_over_enable", 32'h0);

        // Operand sweep
        foreach (sweep_ops[o]) begin
            foreach (vals[i]) begin
                foreach (vals[j]) begin
                    do_op(sweep_ops[o], vals[i], vals[j], 32'h0,
                          model(sweep_ops[o], vals[i], vals[j], 32'h0));
                end
            end
        end

        // Random instructions with occasional idle gaps
        for (int n = 0; n < 400; n++) begin
            k = kind_e'($urandom_range(0, int'(K_BAD)));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            p = $urandom;
            do_op(k, a, b, p, model(k, a, b, p));
            if ($urandom_range(0, 7) == 0) begin
                idle(1, model(k, a, b, p));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
